// File: rtl/alu_acc_ctrl_if.sv
// Request/result bus of the accumulator sequencer: one operation in, one result out.
// The master drives requests and consumes results; the slave is the sequencer itself.
interface alu_acc_ctrl_if #(
   parameter int N = 3
);
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_mode;
   logic [N-1:0] in_operand;
   logic         in_load;
   logic         in_use_cb;
   logic [N-1:0] acc;
   logic         cb_flag;
   logic         res_valid;
   logic         res_ready;

   modport master (
      output in_valid, in_mode, in_operand, in_load, in_use_cb, res_ready,
      input  in_ready, acc, cb_flag, res_valid
   );

   modport slave (
      input  in_valid, in_mode, in_operand, in_load, in_use_cb, res_ready,
      output in_ready, acc, cb_flag, res_valid
   );
endinterface

// File: rtl/alu_acc_ctrl.sv
// Accumulator/sequencer feeding an external combinational ALU: latches one op,
// lets the ALU settle for one EXEC cycle, writes the result back and holds it until taken.
module alu_acc_ctrl #(
   parameter int N = 3
) (
   input  logic             clk,
   input  logic             rst,
   alu_acc_ctrl_if.slave    bus,
   output logic [N-1:0]     alu_A,
   output logic [N-1:0]     alu_B,
   output logic             alu_CB_in,
   output logic [2:0]       alu_mode,
   input  logic [N-1:0]     alu_res,
   input  logic             alu_CB_out
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] acc_q, acc_d;
   logic         cb_q, cb_d;
   logic [N-1:0] b_q, b_d;
   logic         cbin_q, cbin_d;
   logic [2:0]   mode_q, mode_d;
   logic         arith_mode;

   // ADD/SUB (00x) and INC/DEC (11x) produce a carry/borrow; logic modes leave the flag alone.
   assign arith_mode = (mode_q[2:1] == 2'b00) || (mode_q[2:1] == 2'b11);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cb_d    = cb_q;
      b_d     = b_q;
      cbin_d  = cbin_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (bus.in_load) begin
                  acc_d   = bus.in_operand;
                  cb_d    = 1'b0;
                  state_d = DONE;
               end else begin
                  b_d     = bus.in_operand;
                  mode_d  = bus.in_mode;
                  cbin_d  = bus.in_use_cb & cb_q;
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            acc_d = alu_res;
            if (arith_mode) begin
               cb_d = alu_CB_out;
            end
            state_d = DONE;
         end
         DONE: begin
            if (bus.res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cb_q    <= 1'b0;
         b_q     <= '0;
         cbin_q  <= 1'b0;
         mode_q  <= 3'b000;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cb_q    <= cb_d;
         b_q     <= b_d;
         cbin_q  <= cbin_d;
         mode_q  <= mode_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.res_valid = (state_q == DONE);
   assign bus.acc       = acc_q;
   assign bus.cb_flag   = cb_q;

   assign alu_A     = acc_q;
   assign alu_B     = b_q;
   assign alu_CB_in = cbin_q;
   assign alu_mode  = mode_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Bench for alu_acc_ctrl with a behavioural ALU attached and a result scoreboard.
module tb_alu_acc_ctrl;
   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] alu_A, alu_B, alu_res;
   logic         alu_CB_in, alu_CB_out;
   logic [2:0]   alu_mode;
   logic [N:0]   alu_t;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N-1:0] acc;
      logic         cb;
   } exp_t;
   exp_t sb[$];

   alu_acc_ctrl_if #(.N(N)) bus ();

   alu_acc_ctrl #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .alu_A      (alu_A),
      .alu_B      (alu_B),
      .alu_CB_in  (alu_CB_in),
      .alu_mode   (alu_mode),
      .alu_res    (alu_res),
      .alu_CB_out (alu_CB_out)
   );

   always #5 clk = ~clk;

   // Downstream ALU: bit N of alu_t is carry (add/inc) or borrow (sub/dec).
   always_comb begin
      alu_t = '0;
      case (alu_mode)
         3'b000: alu_t = {1'b0, alu_A} + {1'b0, alu_B} + {{N{1'b0}}, alu_CB_in};
         3'b001: alu_t = {1'b0, alu_A} - {1'b0, alu_B} - {{N{1'b0}}, alu_CB_in};
         3'b010: alu_t = {1'b0, alu_A & alu_B};
         3'b011: alu_t = {1'b0, alu_A | alu_B};
         3'b100: alu_t = {1'b0, alu_A ^ alu_B};
         3'b101: alu_t = {1'b0, ~alu_A};
         3'b110: alu_t = {1'b0, alu_A} + 1'b1;
         default: alu_t = {1'b0, alu_A} - 1'b1;
      endcase
   end
   assign alu_res    = alu_t[N-1:0];
   assign alu_CB_out = alu_t[N];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Result monitor: a result is consumed on the edge following a valid&ready sample.
   always @(negedge clk) begin
      if (!rst && bus.res_valid && bus.res_ready) begin
         if (sb.size() == 0) begin
            check_eq("sb_unexpected", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("sb_acc", 32'(bus.acc), 32'(e.acc));
            check_eq("sb_cb", 32'(bus.cb_flag), 32'(e.cb));
            check_eq("alu_A_eq_acc", 32'(alu_A), 32'(bus.acc));
            $display("result acc=%b cb=%b (exp acc=%b cb=%b)", bus.acc, bus.cb_flag, e.acc, e.cb);
         end
      end
   end

   task automatic do_op(input logic [2:0] mode, input logic [N-1:0] operand, input logic load,
                        input logic use_cb, input logic [N-1:0] exp_acc, input logic exp_cb,
                        input logic exp_cbin);
      int   lat;
      exp_t e;
      check_eq("in_ready_before", 32'(bus.in_ready), 32'd1);
      bus.in_valid   = 1'b1;
      bus.in_mode    = mode;
      bus.in_operand = operand;
      bus.in_load    = load;
      bus.in_use_cb  = use_cb;
      e.acc = exp_acc;
      e.cb  = exp_cb;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      if (!load) begin
         check_eq("exec_cb_in", 32'(alu_CB_in), 32'(exp_cbin));
         check_eq("exec_mode", 32'(alu_mode), 32'(mode));
         check_eq("exec_B", 32'(alu_B), 32'(operand));
         check_eq("exec_no_valid", 32'(bus.res_valid), 32'd0);
      end
      while (!bus.res_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq("latency", 32'(lat), load ? 32'd1 : 32'd2);
      $display("op mode=%b opnd=%b load=%b use_cb=%b latency=%0d", mode, operand, load, use_cb, lat);
   endtask

   task automatic finish_op();
      int n = 0;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("back_to_idle", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic run_op(input logic [2:0] mode, input logic [N-1:0] operand, input logic load,
                         input logic use_cb, input logic [N-1:0] exp_acc, input logic exp_cb,
                         input logic exp_cbin);
      do_op(mode, operand, load, use_cb, exp_acc, exp_cb, exp_cbin);
      finish_op();
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_mode    = 3'b000;
      bus.in_operand = '0;
      bus.in_load    = 1'b0;
      bus.in_use_cb  = 1'b0;
      bus.res_ready  = 1'b1;

      // Reset for two cycles, then idle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_acc", 32'(bus.acc), 32'd0);
      check_eq("rst_cb", 32'(bus.cb_flag), 32'd0);
      check_eq("rst_valid", 32'(bus.res_valid), 32'd0);
      check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
      check_eq("rst_B", 32'(alu_B), 32'd0);
      check_eq("rst_mode", 32'(alu_mode), 32'd0);
      check_eq("rst_cbin", 32'(alu_CB_in), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check_eq("idle_acc", 32'(bus.acc), 32'd0);
      check_eq("idle_valid", 32'(bus.res_valid), 32'd0);
      check_eq("idle_ready", 32'(bus.in_ready), 32'd1);

      // mode, operand, load, use_cb, exp acc, exp cb, exp CB_in
      run_op(3'b000, 3'b101, 1'b1, 1'b0, 3'b101, 1'b0, 1'b0);
      run_op(3'b000, 3'b010, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0);
      run_op(3'b000, 3'b001, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
      run_op(3'b000, 3'b001, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
      run_op(3'b001, 3'b011, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0);
      run_op(3'b010, 3'b101, 1'b0, 1'b0, 3'b101, 1'b1, 1'b0);
      run_op(3'b100, 3'b011, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0);
      run_op(3'b101, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0);
      run_op(3'b000, 3'b111, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0);
      run_op(3'b110, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
      run_op(3'b111, 3'b000, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0);
      run_op(3'b111, 3'b000, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0);

      // Back-pressure: DONE held, new requests ignored
      bus.res_ready = 1'b0;
      do_op(3'b000, 3'b011, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         bus.in_valid   = 1'b1;
         bus.in_load    = 1'b1;
         bus.in_operand = 3'b111;
         @(posedge clk);
         #1;
         check_eq("bp_valid", 32'(bus.res_valid), 32'd1);
         check_eq("bp_ready", 32'(bus.in_ready), 32'd0);
         check_eq("bp_acc", 32'(bus.acc), 32'd3);
         $display("backpressure cycle %0d valid=%b ready=%b acc=%b", i, bus.res_valid, bus.in_ready, bus.acc);
      end
      bus.in_valid  = 1'b0;
      bus.in_load   = 1'b0;
      bus.res_ready = 1'b1;
      finish_op();
      check_eq("bp_ignored_acc", 32'(bus.acc), 32'd3);

      // Reset during EXEC abandons the operation
      bus.in_valid   = 1'b1;
      bus.in_mode    = 3'b000;
      bus.in_operand = 3'b010;
      bus.in_load    = 1'b0;
      bus.in_use_cb  = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_eq("pre_rst_exec", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("midrst_acc", 32'(bus.acc), 32'd0);
      check_eq("midrst_cb", 32'(bus.cb_flag), 32'd0);
      check_eq("midrst_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check_eq("midrst_no_valid", 32'(bus.res_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      $display("mid-exec reset acc=%b valid=%b ready=%b", bus.acc, bus.res_valid, bus.in_ready);

      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/alu_acc_ctrl.md
Name: alu_acc_ctrl

Overview:
Accumulator/sequencer stage directly upstream of the N-bit ALU (mode-selected add/sub/AND/OR/XOR/NOT/INC/DEC with CB_in/CB_out carry-borrow).
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operands from registers: A = accumulator, B = latched operand.
- Writes the ALU result back into the accumulator and keeps a carry/borrow flag.
- Presents each result on a valid/ready output port.

Parameters:
N, 3, datapath width of accumulator, operand and ALU ports.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept an operation (high only in IDLE)
in_mode  in  3  ALU mode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 INC, 111 DEC
in_operand  in  N  B operand, or load value when in_load=1
in_load  in  1  1 = load in_operand into accumulator; no ALU operation
in_use_cb  in  1  1 = feed stored flag to ALU CB_in; 0 = CB_in forced 0
alu_A  out  N  to ALU A (equals acc)
alu_B  out  N  to ALU B (registered operand)
alu_CB_in  out  1  to ALU CB_in (registered)
alu_mode  out  3  to ALU mode (registered)
alu_res  in  N  ALU result (combinational from alu_* outputs)
alu_CB_out  in  1  ALU carry/borrow out
acc  out  N  accumulator value
cb_flag  out  1  stored carry/borrow flag
res_valid  out  1  result available (acc/cb_flag valid)
res_ready  in  1  downstream accepts result

Behaviour:
- Reset (rst=1 at an edge, any state, overrides everything):
  - acc=0, cb_flag=0, alu_B=0, alu_CB_in=0, alu_mode=000, res_valid=0, state=IDLE.
  - in_ready=1 in the first cycle after reset.
  - A reset mid-operation abandons the operation: no write-back and no res_valid.
- States: IDLE, EXEC, DONE. in_ready = (state==IDLE). res_valid = (state==DONE).
- IDLE, in_valid=1 at edge k (accept):
  - in_load=0:
    - latch alu_B<=in_operand, alu_mode<=in_mode, alu_CB_in<=(in_use_cb ? cb_flag : 0).
    - Go to EXEC.
  - in_load=1:
    - acc<=in_operand, cb_flag<=0; alu_* registers unchanged.
    - Go to DONE directly (result visible after edge k).
  - in_valid=0: hold state.
- EXEC (exactly one cycle; ALU inputs stable, alu_res settles):
  - At edge k+1: acc<=alu_res, then go to DONE.
  - Arithmetic modes (000, 001, 110, 111): cb_flag<=alu_CB_out.
  - Logic modes (010, 011, 100, 101): cb_flag unchanged.
- Latency: accept edge k -> res_valid=1 after edge k+1 (ALU op) or after edge k (load).
- DONE:
  - res_valid=1 is held; acc and cb_flag are stable.
  - Edge with res_ready=1 -> IDLE; res_valid drops in the next cycle.
  - No new request is accepted in the same cycle (in_ready=0 in DONE), so throughput is at most 1 op per 3 cycles.
- in_valid, in_mode and in_operand are ignored outside IDLE.
- alu_A is always wired to acc (no separate register).
- Width rules:
  - All results wrap modulo 2^N.
  - Overflow/underflow is reported only through alu_CB_out, captured into cb_flag.
- Back-pressure: res_ready held low keeps the block in DONE indefinitely with all outputs stable.
- in_mode values are decoded exactly as listed; X/Z are not sanitised.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> acc=000, cb_flag=0, res_valid=0, in_ready=1; in_valid=0 for 5 cycles -> no change.
- Load + ADD chain (N=3): load 101 -> res_valid after 1 edge, acc=101, cb_flag=0; ADD B=010, use_cb=0 -> acc=111, cb=0, res_valid 2 edges after accept; ADD B=001 -> acc=000, cb=1.
- Carry propagate: after the previous step (cb=1), ADD B=001, use_cb=1 -> alu_CB_in=1, acc=010, cb=0; SUB B=011, use_cb=0 from acc=010 -> acc=111, cb=1 (borrow).
- Logic preserves flag: with cb=1, acc=111: AND B=101 -> acc=101, cb=1; XOR B=011 -> acc=110, cb=1; NOT -> acc=001, cb=1.
- INC/DEC wrap: load 111, INC -> acc=000, cb=1; DEC -> acc=111, cb=1; DEC -> acc=110, cb=0.
- Handshake and reset: hold res_ready=0 for 4 cycles in DONE -> res_valid stays 1, in_ready=0, a new in_valid is ignored. Assert rst in the EXEC cycle -> acc=000, no res_valid pulse, state IDLE.
